rx_rr_arbiter: RTL
==================

RX_RR_ARBITER -- requirements
Module: rx_rr_arbiter

Interface
REQ-001 SHALL have parameter NPORTS, default 5, number of input channels (index 0..4 = N,S,E,W,L).
REQ-002 SHALL have parameter DATA_W, default 24, item width (payload + address).
REQ-003 SHALL have parameter DEPTH, default 4, output buffer entries, power of two, at least 2.
REQ-004 SHALL have parameter RR_MODE, default 1; 1 = round-robin, 0 = fixed priority with index 0 highest.
REQ-005 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high.
REQ-007 SHALL have port in_valid, input, NPORTS, channel i holds an item.
REQ-008 SHALL have port in_item, input, NPORTS*DATA_W, channel i at bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port in_read, output, NPORTS, one-hot pop strobe to channel i.
REQ-010 SHALL have port out_valid, output, 1, buffer non-empty.
REQ-011 SHALL have port out_item, output, DATA_W, head of buffer.
REQ-012 SHALL have port out_read, input, 1, downstream pop.
REQ-013 SHALL have port full, output, 1, buffer holds DEPTH items.

Function
REQ-014 SHALL assert at most one in_read bit per cycle.
REQ-015 SHALL assert in_read[i] combinationally in the same cycle when i is granted, full=0 and reset=0.
REQ-016 SHALL write the granted in_item into the buffer at the clock edge that ends the in_read cycle.
REQ-017 SHALL search in RR_MODE=1 from index ptr upward modulo NPORTS; the first valid channel wins.
REQ-018 SHALL set ptr to (granted index + 1) mod NPORTS on each grant; ptr SHALL hold when no grant occurs or when full=1.
REQ-019 SHALL, in RR_MODE=0, grant the lowest valid index and keep ptr constant at 0.
REQ-020 SHALL make the buffer first-word-fall-through; an item written at edge t is visible on out_item/out_valid after edge t.
REQ-021 SHALL pop the head when out_read=1 and out_valid=1; out_read with out_valid=0 SHALL be ignored.
REQ-022 SHALL keep count unchanged on simultaneous push and pop; count range 0..DEPTH, head/tail pointers wrap modulo DEPTH.
REQ-023 SHALL drive full = (count==DEPTH); a same-cycle pop SHALL NOT unblock a push (no bypass).
REQ-024 SHALL hold out_item stable while out_valid=1 and no pop occurs.

Reset
REQ-025 SHALL, while reset=1, clear count, head, tail and ptr to 0, and drive in_read=0, out_valid=0, full=0.
REQ-026 SHALL discard buffered items when reset is asserted mid-operation; contents of out_item are don't-care while out_valid=0.

Structure
REQ-027 SHALL place the NPORTS default, the DATA_W default and the port index constants PORT_N..PORT_L in shared package noc_pkg.
REQ-028 SHALL implement the buffer as sub-module rx_sync_fifo (DATA_W, DEPTH); grant logic and ptr stay in rx_rr_arbiter.

Verification
REQ-029 SHALL cover this scenario: RR_MODE=1, all five in_valid held high, out_read=1 -> grants in order 0,1,2,3,4,0 on consecutive cycles.
REQ-030 SHALL cover this scenario: RR_MODE=0, in_valid=5'b10110 -> in_read=5'b00010 every cycle.
REQ-031 SHALL cover this scenario: out_read=0, channel 2 valid with items 0xA1..0xA5 -> 4 writes, then full=1 and in_read=0; one pop -> full drops next cycle, 0xA5 accepted the following cycle.
REQ-032 SHALL cover this scenario: push and pop every cycle for 10 cycles with DEPTH=4 -> count constant, pointers wrap, output order equals input order.
REQ-033 SHALL cover this scenario: reset for 1 cycle with 3 items buffered and ptr=3 -> next cycle out_valid=0, full=0, first grant goes to index 0.
REQ-034 SHALL cover this scenario: only channel 4 valid while ptr=1 -> channel 4 granted, ptr becomes 0.

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg
//   Shared constants for the network-on-chip receive path.
//   Holds the default channel count and item width used by the receive
//   arbiter and its interface, plus the symbolic channel indices
//   (north, south, east, west, local) so callers never hard-code them.
//   No ports; import with "import noc_pkg::*;".
package noc_pkg;

  // Five channels: N, S, E, W and the local injection port.
  localparam int NPORTS_DEFAULT = 5;

  // Item = payload plus routing address.
  localparam int DATA_W_DEFAULT = 24;

  // Channel indices, in the order the arbiter searches them.
  localparam int PORT_N = 0;
  localparam int PORT_S = 1;
  localparam int PORT_E = 2;
  localparam int PORT_W = 3;
  localparam int PORT_L = 4;

  // Convenience type for one item at the default width.
  typedef logic [DATA_W_DEFAULT-1:0] noc_item_t;

endpackage

// File: rtl/rx_rr_arbiter_if.sv
// rx_rr_arbiter_if
//   Bundles the channel-side and downstream-side handshake of the receive
//   arbiter.
//   Signals:
//     in_valid  [NPORTS]         channel i holds an item
//     in_item   [NPORTS*DATA_W]  channel i item at [i*DATA_W +: DATA_W]
//     in_read   [NPORTS]         one-hot pop strobe back to channel i
//     out_valid                  output buffer non-empty
//     out_item  [DATA_W]         head of the output buffer
//     out_read                   downstream pops the head
//     full                       output buffer holds DEPTH items
//   Modports:
//     master  the environment (channels + downstream consumer)
//     slave   the arbiter itself
interface rx_rr_arbiter_if
  import noc_pkg::*;
#(
  parameter int NPORTS = NPORTS_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
);

  logic [NPORTS-1:0]        in_valid;
  logic [NPORTS*DATA_W-1:0] in_item;
  logic [NPORTS-1:0]        in_read;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_item;
  logic                     out_read;
  logic                     full;

  modport master (
    output in_valid,
    output in_item,
    output out_read,
    input  in_read,
    input  out_valid,
    input  out_item,
    input  full
  );

  modport slave (
    input  in_valid,
    input  in_item,
    input  out_read,
    output in_read,
    output out_valid,
    output out_item,
    output full
  );

endinterface

// File: rtl/rx_sync_fifo.sv
// rx_sync_fifo
//   Single-clock first-word-fall-through FIFO used as the arbiter's output
//   buffer. The head entry is visible on head_data as soon as it is written.
//   Ports:
//     clk        clock, all state on rising edge
//     reset      synchronous active-high, empties the FIFO
//     push       write push_data at the tail (ignored when full)
//     push_data  [DATA_W] item to write
//     pop        remove the head (ignored when empty)
//     head_data  [DATA_W] current head entry
//     head_valid FIFO holds at least one entry
//     full       FIFO holds DEPTH entries
//   DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module rx_sync_fifo
  import noc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_valid,
  output logic              full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     head_q, head_d;
  logic [AW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  // A push is refused while full even if a pop happens in the same cycle:
  // the free slot only becomes usable after the edge.
  always_comb begin
    full       = (count_q == CW'(DEPTH));
    head_valid = (count_q != '0);
    do_push    = push && !full;
    do_pop     = pop && head_valid;
    head_data  = mem_q[head_q];
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (do_push) begin
      mem_d[tail_q] = push_data;
      tail_d        = tail_q + 1'b1;
    end
    if (do_pop) begin
      head_d = head_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; stale entries are unreachable once count is 0.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/rx_rr_arbiter.sv
// rx_rr_arbiter
//   Picks one of NPORTS receive channels per cycle and moves its item into a
//   DEPTH-entry first-word-fall-through output buffer.
//   RR_MODE=1: round-robin, search starts at ptr and wraps; ptr moves to the
//              slot after each granted channel.
//   RR_MODE=0: fixed priority, lowest valid index wins, ptr stays 0.
//   Ports:
//     clk    clock, all state on rising edge
//     reset  synchronous active-high; clears ptr and the buffer and forces
//            in_read, out_valid and full low while asserted
//     bus    rx_rr_arbiter_if.slave (in_valid/in_item/in_read,
//            out_valid/out_item/out_read, full)
module rx_rr_arbiter
  import noc_pkg::*;
#(
  parameter int NPORTS  = NPORTS_DEFAULT,
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int DEPTH   = 4,
  parameter int RR_MODE = 1
) (
  input  logic           clk,
  input  logic           reset,
  rx_rr_arbiter_if.slave bus
);

  localparam int PTR_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [PTR_W:0] NPORTS_EXT = (PTR_W+1)'(NPORTS);

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  start_idx;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W:0]    cand_ext;
  logic              grant_found;
  logic              grant_en;
  logic [NPORTS-1:0] grant_onehot;
  logic [DATA_W-1:0] push_data;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_valid;
  logic              fifo_full;
  logic              pop;

  always_comb begin
    start_idx = (RR_MODE != 0) ? ptr_q : '0;
  end

  // Walk the channels starting at start_idx; the candidate index is kept one
  // bit wider so start+offset can be folded back below NPORTS without
  // overflowing when NPORTS is not a power of two.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_ext    = '0;
    for (int k = 0; k < NPORTS; k++) begin
      cand_ext = {1'b0, start_idx} + (PTR_W+1)'(k);
      if (cand_ext >= NPORTS_EXT) begin
        cand_ext = cand_ext - NPORTS_EXT;
      end
      if (!grant_found && bus.in_valid[cand_ext[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand_ext[PTR_W-1:0];
      end
    end
  end

  // A grant only takes effect when the buffer can accept it this cycle.
  always_comb begin
    grant_en     = grant_found && !fifo_full && !reset;
    grant_onehot = '0;
    if (grant_en) begin
      grant_onehot[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    push_data = '0;
    for (int k = 0; k < NPORTS; k++) begin
      if (grant_idx == PTR_W'(k)) begin
        push_data = bus.in_item[k*DATA_W +: DATA_W];
      end
    end
  end

  // ptr only moves on an accepted grant, so a blocked (full) cycle keeps the
  // same channel first in line.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_en && (RR_MODE != 0)) begin
      if (grant_idx == PTR_W'(NPORTS - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= PTR_W'(PORT_N);
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    pop = bus.out_read && fifo_valid && !reset;
  end

  rx_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (grant_en),
    .push_data  (push_data),
    .pop        (pop),
    .head_data  (fifo_head),
    .head_valid (fifo_valid),
    .full       (fifo_full)
  );

  // Status is masked during reset because the buffer count only clears at
  // the reset edge.
  always_comb begin
    bus.in_read   = grant_onehot;
    bus.out_valid = fifo_valid && !reset;
    bus.full      = fifo_full && !reset;
    bus.out_item  = fifo_head;
  end

endmodule
